// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset PC default, PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR      = 32'd4;

  // Instructions are word aligned; the low two address bits are always dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer parking a completed fetch (instruction + PC+4) while the pipe is stalled.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clr,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  // load wins over clr; the fetch FSM never asserts both in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc4   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc4   <= pc4_d;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request, IF/ID register and stall skid buffer.
// Optional branch delay slot behaviour is enabled by defining FETCH_DELAY_SLOT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_plus4_o,
  output logic        ifid_valid_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] ST_BOOT  = FS_BOOT;
  localparam logic [1:0] ST_FETCH = FS_FETCH;
  localparam logic [1:0] ST_HOLD  = FS_HOLD;

  // Handshake: a fetch completes on any rising edge where imem_req_o and
  // imem_ready_i are both high; imem_addr_o is the PC and is only changed by
  // that completion or by a redirect.

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_plus4, next_seq;
  logic        fetch_done;
  logic        ifid_load, ifid_bubble;
  logic [31:0] ifid_instr_nxt, ifid_pc4_nxt;
  logic        skid_load, skid_clr, skid_valid;
  logic [31:0] skid_instr, skid_pc4;

  assign pc_plus4    = pc + PC_INCR;
  assign fetch_done  = (state == ST_FETCH) && imem_ready_i;
  assign imem_req_o  = (state == ST_FETCH);
  assign imem_addr_o = pc;
  assign dbg_state_o = state;

`ifdef FETCH_DELAY_SLOT_EN
  logic        pend_valid;
  logic [31:0] pend_pc;

  // A redirect seen in the same cycle as a transfer takes effect immediately.
  always_comb begin
    next_seq = pc_plus4;
    if (redirect_i)      next_seq = align_pc(redirect_pc_i);
    else if (pend_valid) next_seq = pend_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (ifid_load) begin
      pend_valid <= 1'b0;
    end else if (redirect_i) begin
      pend_valid <= 1'b1;
      pend_pc    <= align_pc(redirect_pc_i);
    end
  end
`else
  assign next_seq = pc_plus4;
`endif

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    ifid_load      = 1'b0;
    ifid_bubble    = 1'b0;
    ifid_instr_nxt = imem_rdata_i;
    ifid_pc4_nxt   = pc_plus4;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_FETCH;
        if (!stall_i) ifid_bubble = 1'b1;
      end
      ST_FETCH: begin
        if (fetch_done && !stall_i) begin
          ifid_load = 1'b1;
          pc_nxt    = next_seq;
        end else if (fetch_done) begin
          skid_load = 1'b1;
          state_nxt = ST_HOLD;
        end else if (!stall_i) begin
          ifid_bubble = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall_i && skid_valid) begin
          ifid_load      = 1'b1;
          ifid_instr_nxt = skid_instr;
          ifid_pc4_nxt   = skid_pc4;
          pc_nxt         = next_seq;
          skid_clr       = 1'b1;
          state_nxt      = ST_FETCH;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
`ifndef FETCH_DELAY_SLOT_EN
    // Redirect squashes whatever is completing or parked and refetches at once.
    if (redirect_i) begin
      ifid_load   = 1'b0;
      ifid_bubble = 1'b1;
      skid_load   = 1'b0;
      skid_clr    = 1'b1;
      pc_nxt      = align_pc(redirect_pc_i);
      state_nxt   = ST_FETCH;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_BOOT;
      pc              <= RESET_PC;
      ifid_valid_o    <= 1'b0;
      ifid_instr_o    <= '0;
      ifid_pc_plus4_o <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ifid_load) begin
        ifid_valid_o    <= 1'b1;
        ifid_instr_o    <= ifid_instr_nxt;
        ifid_pc_plus4_o <= ifid_pc4_nxt;
      end else if (ifid_bubble) begin
        ifid_valid_o <= 1'b0;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clr     (skid_clr),
    .instr_d (imem_rdata_i),
    .pc4_d   (pc_plus4),
    .valid   (skid_valid),
    .instr   (skid_instr),
    .pc4     (skid_pc4)
  );

endmodule
